// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: receiver FSM state encoding,
// oversampling constants and the parity helper.
//------------------------------------------------------------------------------
package uart_pkg;

   // Receiver FSM states; PARITY is only entered when parity is compiled in
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   // Ticks per bit period and the tick index of the start-bit centre
   localparam int OVERSAMPLE = 16;
   localparam int MID_START  = 7;

   // Expected parity bit for a data word: even parity makes the total count
   // of ones even, odd parity makes it odd
   function automatic logic parity_bit(input logic [15:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
//------------------------------------------------------------------------------
// baud_tick_gen
// Free-running divider producing a one-cycle oversample tick every DIVISOR
// clocks. It is never re-aligned to the data stream.
// Ports:
//   i_clk  - system clock
//   i_rst  - asynchronous active-high reset
//   o_tick - high for the one cycle where the count equals DIVISOR-1
//------------------------------------------------------------------------------
module baud_tick_gen #(
   parameter int DIVISOR = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam int            CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

   logic [CW-1:0] cnt_r;

   // Divider counter: 0..DIVISOR-1 then wrap
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_r <= '0;
      end else if (cnt_r == LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   assign o_tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// uart_rx_fifo
// Oversampling UART receiver (8N1 by default) feeding a show-ahead byte FIFO.
// Optional parity checking is compiled in with macro UART_RX_PARITY_EN, which
// adds parameter PARITY_ODD and output o_parity_err.
// Ports:
//   i_clk, i_rst     - clock, asynchronous active-high reset
//   i_uart_rx        - serial line (idles high)
//   i_rd             - pop the head byte
//   o_data           - head byte (valid while o_empty = 0)
//   o_empty, o_full  - FIFO status
//   o_rx_done_tick   - pulse: good byte pushed
//   o_frame_err      - pulse: stop bit sampled low
//   o_overrun        - pulse: good byte dropped, FIFO full
//   o_parity_err     - pulse: parity mismatch (UART_RX_PARITY_EN only)
//------------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 19200,
   parameter int DATA_BITS  = 8,
   parameter int SB_TICK    = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int DIVISOR    = CLK_FREQ / (BAUD * OVERSAMPLE)
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_uart_rx,
   input  logic                 i_rd,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_empty,
   output logic                 o_full,
   output logic                 o_rx_done_tick,
   output logic                 o_frame_err,
   output logic                 o_overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 o_parity_err
`endif
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int NW  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
   localparam int SCW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

   logic                 sync1_r;
   logic                 rx_s;          // synchronized line (register)
   logic                 tick_s;
   uart_state_t          state_r, state_nx_s;
   logic [SCW-1:0]       s_cnt_r, s_cnt_nx_s;
   logic [NW-1:0]        n_cnt_r, n_cnt_nx_s;
   logic [DATA_BITS-1:0] shreg_r, shreg_nx_s;
   logic                 stop_hit_s;
   logic                 push_s, pop_s, done_s, ferr_s, ovr_s;
   logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
   logic [AW:0]          wr_ptr_r, rd_ptr_r;
   logic                 empty_s, full_s;
`ifdef UART_RX_PARITY_EN
   logic                 perr_r, perr_nx_s, perr_pulse_s;
`endif

   baud_tick_gen #(.DIVISOR(DIVISOR)) u_baud (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .o_tick (tick_s)
   );

   // Two-flop synchronizer; resets to the idle (high) line level
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_r <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         sync1_r <= i_uart_rx;
         rx_s    <= sync1_r;
      end
   end

   // Receiver FSM state and datapath registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= IDLE;
         s_cnt_r <= '0;
         n_cnt_r <= '0;
         shreg_r <= '0;
`ifdef UART_RX_PARITY_EN
         perr_r  <= 1'b0;
`endif
      end else begin
         state_r <= state_nx_s;
         s_cnt_r <= s_cnt_nx_s;
         n_cnt_r <= n_cnt_nx_s;
         shreg_r <= shreg_nx_s;
`ifdef UART_RX_PARITY_EN
         perr_r  <= perr_nx_s;
`endif
      end
   end

   // Receiver FSM next-state logic; all sampling happens on oversample ticks
   always_comb begin
      state_nx_s = state_r;
      s_cnt_nx_s = s_cnt_r;
      n_cnt_nx_s = n_cnt_r;
      shreg_nx_s = shreg_r;
      stop_hit_s = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_nx_s  = perr_r;
`endif
      case (state_r)
         IDLE: begin
            if (!rx_s) begin
               state_nx_s = START;
               s_cnt_nx_s = '0;
            end else begin
               state_nx_s = IDLE;
            end
         end
         START: begin
            if (tick_s && (s_cnt_r == SCW'(MID_START))) begin
               // Still low at mid-bit: real start bit, otherwise a glitch
               if (!rx_s) begin
                  state_nx_s = DATA;
                  s_cnt_nx_s = '0;
                  n_cnt_nx_s = '0;
               end else begin
                  state_nx_s = IDLE;
               end
            end else if (tick_s) begin
               s_cnt_nx_s = s_cnt_r + SCW'(1);
            end else begin
               s_cnt_nx_s = s_cnt_r;
            end
         end
         DATA: begin
            if (tick_s && (s_cnt_r == SCW'(OVERSAMPLE - 1))) begin
               shreg_nx_s = {rx_s, shreg_r[DATA_BITS-1:1]};
               s_cnt_nx_s = '0;
               n_cnt_nx_s = n_cnt_r + NW'(1);
               if (n_cnt_r == NW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_nx_s = PARITY;
`else
                  state_nx_s = STOP;
`endif
               end else begin
                  state_nx_s = DATA;
               end
            end else if (tick_s) begin
               s_cnt_nx_s = s_cnt_r + SCW'(1);
            end else begin
               s_cnt_nx_s = s_cnt_r;
            end
         end
         PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (tick_s && (s_cnt_r == SCW'(OVERSAMPLE - 1))) begin
               perr_nx_s  = (rx_s != parity_bit(16'(shreg_r), PARITY_ODD));
               s_cnt_nx_s = '0;
               state_nx_s = STOP;
            end else if (tick_s) begin
               s_cnt_nx_s = s_cnt_r + SCW'(1);
            end else begin
               s_cnt_nx_s = s_cnt_r;
            end
`else
            state_nx_s = IDLE;
`endif
         end
         STOP: begin
            if (tick_s && (s_cnt_r == SCW'(SB_TICK - 1))) begin
               stop_hit_s = 1'b1;
               s_cnt_nx_s = '0;
               state_nx_s = IDLE;
            end else if (tick_s) begin
               s_cnt_nx_s = s_cnt_r + SCW'(1);
            end else begin
               s_cnt_nx_s = s_cnt_r;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

   // Stop-bit outcome: framing error wins over parity error; a pop in the
   // same cycle frees a slot so a full FIFO still accepts the byte
   always_comb begin
      pop_s  = i_rd & ~empty_s;
      push_s = 1'b0;
      done_s = 1'b0;
      ferr_s = 1'b0;
      ovr_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pulse_s = 1'b0;
`endif
      if (stop_hit_s) begin
         if (!rx_s) begin
            ferr_s = 1'b1;
`ifdef UART_RX_PARITY_EN
         end else if (perr_r) begin
            perr_pulse_s = 1'b1;
`endif
         end else if (!full_s || pop_s) begin
            push_s = 1'b1;
            done_s = 1'b1;
         end else begin
            ovr_s = 1'b1;
         end
      end else begin
         push_s = 1'b0;
      end
   end

   // Registered status pulses, aligned with the push edge
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_rx_done_tick <= 1'b0;
         o_frame_err    <= 1'b0;
         o_overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_parity_err   <= 1'b0;
`endif
      end else begin
         o_rx_done_tick <= done_s;
         o_frame_err    <= ferr_s;
         o_overrun      <= ovr_s;
`ifdef UART_RX_PARITY_EN
         o_parity_err   <= perr_pulse_s;
`endif
      end
   end

   // FIFO storage and pointers; storage is cleared so the head reads 0 after reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= shreg_r;
            wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   assign o_data  = mem_r[rd_ptr_r[AW-1:0]];
   assign o_empty = empty_s;
   assign o_full  = full_s;

endmodule
